i2s_tx_serializer: RTL and testbench

//  Output end of the equalizer audio path: accepts 24-bit signed stereo sample pairs from the filter stage
//  and serializes them to an external DAC in Philips I2S format. Generates BCLK/LRCLK from clk.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/i2s_tx_serializer_if.sv | 22 ++
 rtl/i2s_sample_fifo.sv | 53 +++++
 rtl/i2s_tx_serializer.sv | 154 +++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types: sample widths, stereo pair and the I2S transmitter state encoding.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned I2S_SLOT_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } tx_state_t;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample handshake between the filter stage (master) and the I2S serializer (slave).
interface i2s_tx_serializer_if #(
  parameter int unsigned DATA_W = 24
);

  logic                     sample_valid;
  logic signed [DATA_W-1:0] left_sample;
  logic signed [DATA_W-1:0] right_sample;
  logic                     sample_ready;
  logic                     sample_req;

  modport master (
    output sample_valid, left_sample, right_sample,
    input  sample_ready, sample_req
  );

  modport slave (
    input  sample_valid, left_sample, right_sample,
    output sample_ready, sample_req
  );

endinterface

// File: rtl/i2s_sample_fifo.sv
// Synchronous stereo-pair FIFO; push and pop in the same clk are accepted even when full.
module i2s_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned W     = $bits(stereo_t),
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: BCLK/LRCLK generation, per-frame pair pop with sample_req strobe,
// MSB-first shift-out of a 2*SLOT_W frame word, sticky overflow/underrun flags.
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W     = SAMPLE_W,
  parameter int unsigned SLOT_W     = I2S_SLOT_W,
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  i2s_tx_serializer_if.slave            bus,
  input  logic                          clear_flags,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic                          overflow,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned PW         = $clog2(FRAME_BITS);
  localparam int unsigned DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  tx_state_t               state;
  logic [DW-1:0]           div_cnt;
  logic [PW-1:0]           bit_pos;
  logic [PW-1:0]           next_pos;
  logic                    bclk;
  logic                    lrclk;
  logic                    req;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   load_word;
  logic                    div_term;
  logic                    bclk_fall;
  logic                    frame_wrap;
  logic                    lr_next;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [2*DATA_W-1:0]     fifo_dout;

  i2s_sample_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     ({bus.left_sample, bus.right_sample}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign div_term   = (div_cnt == DW'(BCLK_DIV - 1));
  assign bclk_fall  = (state == RUN) && div_term && bclk;
  assign frame_wrap = bclk_fall && (bit_pos == PW'(FRAME_BITS - 1));
  assign next_pos   = frame_wrap ? '0 : bit_pos + 1'b1;
  assign lr_next    = (next_pos >= PW'(SLOT_W - 1)) && (next_pos <= PW'(FRAME_BITS - 2));
  assign fifo_push  = bus.sample_valid && !fifo_full;
  assign fifo_pop   = enable && ((state != RUN) || frame_wrap);

  // Frame word holds each sample left-justified in its slot; an empty FIFO yields silence.
  always_comb begin
    load_word = '0;
    if (!fifo_empty) begin
      load_word[FRAME_BITS-1 -: DATA_W] = fifo_dout[2*DATA_W-1 -: DATA_W];
      load_word[SLOT_W-1 -: DATA_W]     = fifo_dout[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_pos <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      req     <= 1'b0;
      shreg   <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_pos <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
      req     <= 1'b0;
      shreg   <= '0;
    end else begin
      req <= 1'b0;
      case (state)
        IDLE, PRIME: begin
          if (!fifo_empty) begin
            state   <= RUN;
            shreg   <= load_word;
            div_cnt <= '0;
            bit_pos <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            req     <= 1'b1;
          end else begin
            state <= PRIME;
          end
        end
        RUN: begin
          if (div_term) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
              bit_pos <= next_pos;
              lrclk   <= lr_next;
              if (frame_wrap) begin
                shreg <= load_word;
                req   <= 1'b1;
              end else begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else if (clear_flags) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (bus.sample_valid && fifo_full)        overflow <= 1'b1;
      if (enable && frame_wrap && fifo_empty)   underrun <= 1'b1;
    end
  end

  assign bus.sample_ready = !fifo_full;
  assign bus.sample_req   = req;
  assign i2s_bclk         = bclk;
  assign i2s_lrclk        = lrclk;
  assign i2s_sdata        = shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer (DATA_W=24, SLOT_W=32, BCLK_DIV=2, FIFO_DEPTH=4).
module tb_i2s_tx_serializer;
  import audio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear_flags = 1'b0;
  logic       i2s_bclk, i2s_lrclk, i2s_sdata;
  logic       overflow, underrun;
  logic [2:0] fifo_level;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  i2s_tx_serializer_if #(.DATA_W(24)) bus ();

  i2s_tx_serializer #(
    .DATA_W     (24),
    .SLOT_W     (32),
    .BCLK_DIV   (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .bus         (bus),
    .clear_flags (clear_flags),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .overflow    (overflow),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.left_sample  = l;
    bus.right_sample = r;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.sample_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_falls(input int n, output bit ok);
    int   cnt = 0;
    logic prev = i2s_bclk;
    ok = 1'b0;
    for (int i = 0; i < n * 4 + 20; i++) begin
      @(negedge clk);
      if (prev && !i2s_bclk) cnt++;
      prev = i2s_bclk;
      if (cnt == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples sdata/lrclk at each rising BCLK, MSB of the result is bit position 0.
  task automatic capture(output logic [63:0] d, output logic [63:0] lr,
                         output int period, output bit ok);
    int   n = 0;
    int   c1 = 0;
    logic prev = i2s_bclk;
    d = '0; lr = '0; period = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!prev && i2s_bclk) begin
        d[63-n]  = i2s_sdata;
        lr[63-n] = i2s_lrclk;
        if (n == 0) c1 = cyc;
        if (n == 1) period = cyc - c1;
        n++;
      end
      prev = i2s_bclk;
      if (n == 64) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [63:0] d, lr;
  int          period, t0, t1, t2, req_seen, bclk_seen;
  bit          ok;

  initial begin
    bus.sample_valid = 1'b0;
    bus.left_sample  = '0;
    bus.right_sample = '0;
    enable = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_bclk",   64'(i2s_bclk), 0);
    check("rst_lrclk",  64'(i2s_lrclk), 0);
    check("rst_sdata",  64'(i2s_sdata), 0);
    check("rst_req",    64'(bus.sample_req), 0);
    check("rst_ready",  64'(bus.sample_ready), 1);
    check("rst_level",  64'(fifo_level), 0);
    check("rst_ovf",    64'(overflow), 0);
    check("rst_udr",    64'(underrun), 0);

    reset_n = 1'b1;
    req_seen = 0; bclk_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sample_req) req_seen++;
      if (i2s_bclk || i2s_lrclk || i2s_sdata) bclk_seen++;
    end
    check("prime_state", 64'(dut.state), 64'(PRIME));
    check("prime_req",   64'(req_seen), 0);
    check("prime_i2s",   64'(bclk_seen), 0);

    // First frame: boundary sample values
    push_pair(24'h800001, 24'h7FFFFE);
    wait_req(ok);
    check("f1_req_tmo", 64'(ok), 1);
    t0 = cyc;
    capture(d, lr, period, ok);
    check("f1_cap_tmo", 64'(ok), 1);
    check("f1_data",    d, {24'h800001, 8'h00, 24'h7FFFFE, 8'h00});
    check("f1_lrclk",   lr, 64'h0000_0001_FFFF_FFFE);
    check("bclk_period", 64'(period), 4);
    check("f1_no_udr",  64'(underrun), 0);

    // Starved stream
    wait_req(ok);
    check("f2_req_tmo", 64'(ok), 1);
    t1 = cyc;
    check("req_interval1", 64'(t1 - t0), 256);
    check("f2_udr",     64'(underrun), 1);
    capture(d, lr, period, ok);
    check("f2_cap_tmo", 64'(ok), 1);
    check("f2_data",    d, 64'h0);
    wait_req(ok);
    check("f3_req_tmo", 64'(ok), 1);
    t2 = cyc;
    check("req_interval2", 64'(t2 - t1), 256);

    // Stopped: fill FIFO and overflow
    enable = 1'b0;
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    @(negedge clk);
    check("stop_bclk",  64'(i2s_bclk), 0);
    check("clr_udr",    64'(underrun), 0);
    push_pair(24'h123456, 24'hABCDEF);
    push_pair(24'h000001, 24'hFFFFFF);
    push_pair(24'h5A5A5A, 24'hA5A5A5);
    push_pair(24'h7FFFFF, 24'h800000);
    check("full_ready", 64'(bus.sample_ready), 0);
    check("full_level", 64'(fifo_level), 4);
    check("full_ovf0",  64'(overflow), 0);
    push_pair(24'h111111, 24'h222222);
    check("ovf_set",    64'(overflow), 1);
    check("ovf_level",  64'(fifo_level), 4);

    enable = 1'b1;
    wait_req(ok);
    check("p1_req_tmo", 64'(ok), 1);
    capture(d, lr, period, ok);
    check("p1_data",    d, {24'h123456, 8'h00, 24'hABCDEF, 8'h00});
    wait_req(ok);
    check("p2_req_tmo", 64'(ok), 1);
    capture(d, lr, period, ok);
    check("p2_data",    d, {24'h000001, 8'h00, 24'hFFFFFF, 8'h00});

    // Disable mid-frame at p=40
    wait_req(ok);
    check("p3_req_tmo", 64'(ok), 1);
    check("p3_level",   64'(fifo_level), 1);
    wait_falls(40, ok);
    check("p40_tmo",    64'(ok), 1);
    check("p40_lrclk",  64'(i2s_lrclk), 1);
    enable = 1'b0;
    @(negedge clk);
    check("dis_bclk",   64'(i2s_bclk), 0);
    check("dis_lrclk",  64'(i2s_lrclk), 0);
    check("dis_sdata",  64'(i2s_sdata), 0);
    check("dis_level",  64'(fifo_level), 1);
    check("dis_state",  64'(dut.state), 64'(IDLE));

    enable = 1'b1;
    wait_req(ok);
    check("p4_req_tmo", 64'(ok), 1);
    capture(d, lr, period, ok);
    check("p4_data",    d, {24'h7FFFFF, 8'h00, 24'h800000, 8'h00});
    check("p4_lrclk",   lr, 64'h0000_0001_FFFF_FFFE);
    enable = 1'b0;

    // Reset mid-frame with 3 pairs queued
    push_pair(24'hFFFFFF, 24'h000000);
    push_pair(24'h010203, 24'h040506);
    push_pair(24'h0A0B0C, 24'h0D0E0F);
    push_pair(24'h102030, 24'h405060);
    enable = 1'b1;
    wait_req(ok);
    check("q1_req_tmo", 64'(ok), 1);
    wait_falls(10, ok);
    check("p10_tmo",    64'(ok), 1);
    repeat (2) @(negedge clk);
    check("p10_bclk",   64'(i2s_bclk), 1);
    check("p10_sdata",  64'(i2s_sdata), 1);
    check("p10_level",  64'(fifo_level), 3);
    check("p10_ovf",    64'(overflow), 1);
    reset_n = 1'b0;
    #1;
    check("mrst_bclk",  64'(i2s_bclk), 0);
    check("mrst_lrclk", 64'(i2s_lrclk), 0);
    check("mrst_sdata", 64'(i2s_sdata), 0);
    check("mrst_req",   64'(bus.sample_req), 0);
    check("mrst_ready", 64'(bus.sample_ready), 1);
    check("mrst_level", 64'(fifo_level), 0);
    check("mrst_ovf",   64'(overflow), 0);
    check("mrst_udr",   64'(underrun), 0);
    check("mrst_state", 64'(dut.state), 64'(IDLE));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
